ped_xing_ctrl: RTL and testbench
================================

# ped_xing_ctrl

Parametrised pedestrian-crossing controller, the successor to the fixed-timing button-actioned traffic light. It sequences one road signal and one pedestrian signal from a one-cycle time-base strobe, and latches pedestrian requests with a wait lamp. It adds an all-red clearance phase, a flashing pedestrian-clearance phase and a flashing-yellow night mode, and exposes the remaining phase time for a countdown display. Durations are parameters; the block runs on the system clock, with `tick` supplied by the shared seconds prescaler.

## Interface
- `CNT_W`, 8: width of phase timer and `countdown`.
- `T_GREEN_MIN`, 60: minimum road-green duration, in ticks.
- `T_YELLOW`, 4: road-yellow duration, in ticks.
- `T_CLEAR`, 2: all-red clearance duration, in ticks; used before and after the pedestrian phase.
- `T_WALK`, 20: steady pedestrian-green duration, in ticks.
- `T_PED_CLEAR`, 6: flashing pedestrian-green duration, in ticks.

Ports:
- `clk` input 1: single clock; everything is rising-edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `tick` input 1: time-base strobe, one cycle high per second; may be held high (one tick per cycle).
- `btn` input 1: pedestrian button, already synchronous to `clk`; level.
- `night` input 1: night-mode request, level.
- `traff_green`, `traff_yellow`, `traff_red` output 1 each: road lamps.
- `ped_green`, `ped_red` output 1 each: pedestrian lamps.
- `req_pending` output 1: "wait" lamp, showing the latched request.
- `countdown` output CNT_W: remaining ticks in the current timed phase; 0 in untimed states.

## Operation
- Phase timer `remain`:
  - Loaded with the state's duration on entry to a timed state.
  - Decrements on each `tick`.
  - Each timed state lasts exactly its duration in ticks: on a `tick` with `remain`==1, the FSM transitions and reloads.
  - `countdown` = `remain`.
- Request latch `req`:
  - Set on a `btn` rising edge (`btn` & ~`btn_d`).
  - Set is ignored in WALK, PED_CLEAR and NIGHT.
  - Cleared on the cycle the FSM enters WALK, and on entry to NIGHT.
  - If set and clear coincide, clear wins.
  - `req_pending` = `req`.
- Flash phase `fl`:
  - Toggles on every `tick` in PED_CLEAR and NIGHT.
  - Forced to 1 on entry to either state.
- States and lamp outputs (all other outputs 0):
  - GREEN (timed, `T_GREEN_MIN`): `traff_green`, `ped_red`.
  - GREEN_WAIT (untimed): `traff_green`, `ped_red`.
  - YELLOW (timed): `traff_yellow`, `ped_red`.
  - ALL_RED_1 (timed, `T_CLEAR`): `traff_red`, `ped_red`.
  - WALK (timed): `traff_red`, `ped_green`.
  - PED_CLEAR (timed): `traff_red`, `ped_green`=`fl`.
  - ALL_RED_2 (timed, `T_CLEAR`): `traff_red`, `ped_red`.
  - NIGHT (untimed): `traff_yellow`=`fl`; pedestrian lamps dark.
- Transitions:
  - GREEN expiry: YELLOW if `night`|`req`, else GREEN_WAIT.
  - GREEN_WAIT: on the next clock after `night`|`req` is seen, go to YELLOW; no tick alignment.
  - YELLOW expiry: NIGHT if `night`, else ALL_RED_1. `night` is sampled at expiry; if both are active, night wins and the request is dropped.
  - ALL_RED_1 → WALK → PED_CLEAR → ALL_RED_2 → GREEN, each on expiry.
  - NIGHT: when `night`=0, go to ALL_RED_2 on the next clock.
- Lamp outputs are decoded from the registered state and `fl` only. There is no combinational path from inputs to outputs.
- Arithmetic and parameter rules:
  - All durations must be ≥1 and ≤2^CNT_W−1.
  - Elaboration fails otherwise.
  - `remain` never wraps.

## Timing
- Reset (`rst_n`=0 at a rising edge): next cycle the state is GREEN.
  - `remain`=`T_GREEN_MIN`, `req`=0, `btn_d`=0, `fl`=0.
  - Outputs: `traff_green`=1, `ped_red`=1, all other lamps 0, `req_pending`=0, `countdown`=`T_GREEN_MIN`.
- Reset mid-phase has the same effect, regardless of `tick`.
- State, `countdown` and lamps update one clock after the qualifying `tick` or input.
- `req_pending` rises one clock after the `btn` rising edge.
- A `btn` held high produces one request only; a new rising edge is needed after release.
- Road never shows green while pedestrian is green. At least `T_CLEAR` ticks of all-red precede and follow every pedestrian phase.

## Test plan
- Reset, then `btn` edge at tick 10 (`tick` every cycle):
  - `req_pending` rises 1 cycle later.
  - Green lasts 60 ticks, then yellow 4, all-red 2, walk 20, flash 6 (`ped_green` toggling 1,0,1,0,1,0), all-red 2, green.
  - `req_pending` clears on WALK entry.
- No button for 100 ticks:
  - GREEN_WAIT is entered after tick 60, `countdown`=0, lamps stay green.
  - `btn` edge → YELLOW 2 cycles after the edge (1 to latch, 1 to transition), `countdown`=4.
- `btn` pulses during WALK and PED_CLEAR: `req_pending` stays 0 and the next green runs the full 60 ticks to GREEN_WAIT.
- `night`=1 in GREEN_WAIT:
  - YELLOW 4 ticks, then NIGHT with `traff_yellow` toggling per tick, all other lamps 0.
  - `night`=0 → ALL_RED_2 for 2 ticks → GREEN.
- `night` and a `btn` edge in the same cycle during GREEN: after GREEN expiry → YELLOW → NIGHT, `req` cleared, no WALK.
- `rst_n`=0 for one cycle during WALK with `tick` low: the next cycle shows GREEN, `countdown`=60, `req_pending`=0.

Source files
------------

// File: rtl/ped_xing_ctrl.sv
// ped_xing_ctrl: pedestrian crossing sequencer with all-red clearance, flashing ped clearance and night mode
module ped_xing_ctrl #(
  parameter int CNT_W       = 8,
  parameter int T_GREEN_MIN = 60,
  parameter int T_YELLOW    = 4,
  parameter int T_CLEAR     = 2,
  parameter int T_WALK      = 20,
  parameter int T_PED_CLEAR = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             btn,
  input  logic             night,
  output logic             traff_green,
  output logic             traff_yellow,
  output logic             traff_red,
  output logic             ped_green,
  output logic             ped_red,
  output logic             req_pending,
  output logic [CNT_W-1:0] countdown
);

  function automatic bit bad_dur(input int d);
    return d < 1 || longint'(d) > (longint'(1) << CNT_W) - 1;
  endfunction

  if (bad_dur(T_GREEN_MIN) || bad_dur(T_YELLOW) || bad_dur(T_CLEAR) ||
      bad_dur(T_WALK) || bad_dur(T_PED_CLEAR)) begin : g_bad_dur
    $error("ped_xing_ctrl: every phase duration must be in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] D_GREEN = CNT_W'(T_GREEN_MIN);
  localparam logic [CNT_W-1:0] D_YEL   = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] D_CLR   = CNT_W'(T_CLEAR);
  localparam logic [CNT_W-1:0] D_WALK  = CNT_W'(T_WALK);
  localparam logic [CNT_W-1:0] D_PCLR  = CNT_W'(T_PED_CLEAR);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    GREEN, GREEN_WAIT, YELLOW, ALL_RED_1, WALK, PED_CLEAR, ALL_RED_2, NIGHT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remain;
  logic             req, btn_d, fl;
  logic             btn_rise, expire, go;

  assign btn_rise = btn & ~btn_d;
  assign expire   = tick && remain == ONE;
  assign go       = night || req;

  // phase sequencing; later assignments in the case override the default updates above it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= GREEN;
      remain <= D_GREEN;
      req    <= 1'b0;
      btn_d  <= 1'b0;
      fl     <= 1'b0;
    end else begin
      btn_d <= btn;
      if (btn_rise && !(state inside {WALK, PED_CLEAR, NIGHT})) req <= 1'b1;
      if (tick && remain > ONE) remain <= remain - ONE;
      if (tick && (state == PED_CLEAR || state == NIGHT)) fl <= ~fl;
      case (state)
        GREEN: if (expire) begin
          state  <= go ? YELLOW : GREEN_WAIT;
          remain <= go ? D_YEL : '0;
        end
        GREEN_WAIT: if (go) begin
          state  <= YELLOW;
          remain <= D_YEL;
        end
        YELLOW: if (expire) begin
          state  <= night ? NIGHT : ALL_RED_1;
          remain <= night ? '0 : D_CLR;
          if (night) begin
            req <= 1'b0;
            fl  <= 1'b1;
          end
        end
        ALL_RED_1: if (expire) begin
          state  <= WALK;
          remain <= D_WALK;
          req    <= 1'b0;
        end
        WALK: if (expire) begin
          state  <= PED_CLEAR;
          remain <= D_PCLR;
          fl     <= 1'b1;
        end
        PED_CLEAR: if (expire) begin
          state  <= ALL_RED_2;
          remain <= D_CLR;
        end
        ALL_RED_2: if (expire) begin
          state  <= GREEN;
          remain <= D_GREEN;
        end
        NIGHT: if (!night) begin
          state  <= ALL_RED_2;
          remain <= D_CLR;
        end
      endcase
    end
  end

  // lamp decode from registered state and flash phase only
  always_comb begin
    traff_green  = state == GREEN || state == GREEN_WAIT;
    traff_yellow = state == YELLOW || (state == NIGHT && fl);
    traff_red    = state inside {ALL_RED_1, WALK, PED_CLEAR, ALL_RED_2};
    ped_green    = state == WALK || (state == PED_CLEAR && fl);
    ped_red      = state inside {GREEN, GREEN_WAIT, YELLOW, ALL_RED_1, ALL_RED_2};
    req_pending  = req;
    countdown    = remain;
  end

endmodule

// File: tb/tb_ped_xing_ctrl.sv
// tb_ped_xing_ctrl: vector-table and scoreboard check of ped_xing_ctrl with default timings
module tb_ped_xing_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, tick = 1'b0, btn = 1'b0, night = 1'b0;
  logic       traff_green, traff_yellow, traff_red, ped_green, ped_red, req_pending;
  logic [7:0] countdown;

  int total = 0;
  int bad = 0;

  ped_xing_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn), .night(night),
    .traff_green(traff_green), .traff_yellow(traff_yellow), .traff_red(traff_red),
    .ped_green(ped_green), .ped_red(ped_red), .req_pending(req_pending),
    .countdown(countdown)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] L_G  = 5'b10001;
  localparam logic [4:0] L_Y  = 5'b01001;
  localparam logic [4:0] L_R  = 5'b00101;
  localparam logic [4:0] L_W  = 5'b00110;
  localparam logic [4:0] L_PO = 5'b00100;
  localparam logic [4:0] L_N  = 5'b01000;
  localparam logic [4:0] L_D  = 5'b00000;

  typedef struct {
    logic       r, t, b, n;
    logic [4:0] lamps;
    logic       req;
    logic [7:0] cd;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic add(input bit r, t, b, n, input logic [4:0] l, input bit q, input int c);
    vec_t v;
    v.r = r; v.t = t; v.b = b; v.n = n; v.lamps = l; v.req = q; v.cd = 8'(c);
    vecs.push_back(v);
  endtask

  task automatic phase(input logic [4:0] l, input int len, input bit q, input bit n);
    for (int k = len; k >= 1; k--) add(1, 1, 0, n, l, q, k);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int n;
    // reset, tick-low hold, button edge at tick 10 held for three cycles, full pedestrian cycle
    add(0, 1, 0, 0, L_G, 0, 60);
    add(1, 0, 0, 0, L_G, 0, 60);
    add(1, 0, 0, 0, L_G, 0, 60);
    for (int k = 59; k >= 1; k--) add(1, 1, k >= 48 && k <= 50, 0, L_G, k <= 50, k);
    phase(L_Y, 4, 1, 0);
    phase(L_R, 2, 1, 0);
    phase(L_W, 20, 0, 0);
    for (int k = 6; k >= 1; k--) add(1, 1, 0, 0, k % 2 == 0 ? L_W : L_PO, 0, k);
    phase(L_R, 2, 0, 0);
    // no button: green expires into green-wait, then a button edge
    add(1, 1, 0, 0, L_G, 0, 60);
    phase(L_G, 59, 0, 0);
    repeat (41) add(1, 1, 0, 0, L_G, 0, 0);
    add(1, 1, 1, 0, L_G, 1, 0);
    add(1, 1, 0, 0, L_Y, 1, 4);
    phase(L_Y, 3, 1, 0);
    phase(L_R, 2, 1, 0);
    // button pulses during walk and flash are ignored
    for (int k = 20; k >= 1; k--) add(1, 1, k == 15 || k == 10, 0, L_W, 0, k);
    for (int k = 6; k >= 1; k--) add(1, 1, k == 5 || k == 3, 0, k % 2 == 0 ? L_W : L_PO, 0, k);
    phase(L_R, 2, 0, 0);
    add(1, 1, 0, 0, L_G, 0, 60);
    phase(L_G, 59, 0, 0);
    add(1, 1, 0, 0, L_G, 0, 0);
    // night from green-wait, flashing yellow, button ignored, tick-low holds flash
    add(1, 1, 0, 1, L_Y, 0, 4);
    phase(L_Y, 3, 0, 1);
    add(1, 1, 0, 1, L_N, 0, 0);
    add(1, 1, 1, 1, L_D, 0, 0);
    add(1, 1, 0, 1, L_N, 0, 0);
    add(1, 0, 0, 1, L_N, 0, 0);
    add(1, 1, 0, 1, L_D, 0, 0);
    add(1, 1, 0, 1, L_N, 0, 0);
    add(1, 1, 0, 0, L_R, 0, 2);
    add(1, 1, 0, 0, L_R, 0, 1);
    add(1, 1, 0, 0, L_G, 0, 60);
    // night and button edge together in green: night wins, no walk
    for (int k = 59; k >= 1; k--) add(1, 1, k == 30, k <= 30, L_G, k <= 30, k);
    phase(L_Y, 4, 1, 1);
    add(1, 1, 0, 1, L_N, 0, 0);
    add(1, 1, 0, 1, L_D, 0, 0);
    add(1, 1, 0, 0, L_R, 0, 2);
    add(1, 1, 0, 0, L_R, 0, 1);
    add(1, 1, 0, 0, L_G, 0, 60);
    // reset in the middle of walk with tick low
    for (int k = 59; k >= 1; k--) add(1, 1, k == 55, 0, L_G, k <= 55, k);
    phase(L_Y, 4, 1, 0);
    phase(L_R, 2, 1, 0);
    add(1, 1, 0, 0, L_W, 0, 20);
    add(1, 1, 0, 0, L_W, 0, 19);
    add(0, 0, 0, 0, L_G, 0, 60);
    add(1, 0, 0, 0, L_G, 0, 60);
    add(1, 1, 0, 0, L_G, 0, 59);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].r; tick = vecs[i].t; btn = vecs[i].b; night = vecs[i].n;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("lamps[%0d]", i),
          int'({traff_green, traff_yellow, traff_red, ped_green, ped_red}), int'(e.lamps));
      chk($sformatf("req[%0d]", i), int'(req_pending), int'(e.req));
      chk($sformatf("countdown[%0d]", i), int'(countdown), int'(e.cd));
    end

    // held button yields one request; green still runs exactly 60 ticks
    rst_n = 1'b0; tick = 1'b0; btn = 1'b0; night = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; btn = 1'b1;
    @(posedge clk); #1;
    chk("req_rise", int'(req_pending), 1);
    repeat (4) @(posedge clk);
    #1;
    btn = 1'b0;
    chk("held_cd", int'(countdown), 60);
    chk("held_green", int'(traff_green), 1);
    tick = 1'b1;
    n = 0;
    while (!traff_yellow && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ticks_to_yellow", n, 60);
    chk("yellow_cd", int'(countdown), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
